// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: data/request widths and response-buffer defaults.
package xbar_pkg;

    localparam int unsigned XBAR_DATA_W       = 32;
    localparam int unsigned XBAR_REQ_W        = 67;
    localparam int unsigned RESPBUF_DEPTH_DEF = 4;

    // Read-data word carried on the response path.
    typedef logic [XBAR_DATA_W-1:0] xbar_rdata_t;

endpackage

// File: rtl/respbuf_fifo.sv
// Response FIFO: DEPTH x WIDTH register array with wrapping pointers and an occupancy count.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module respbuf_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/respbuf.sv
// Response-path buffer: buffers slave read data toward the master, counts outstanding
// reads to gate new read issue, and flags protocol errors in a sticky ovf_o.
// Optional build macro RESPBUF_BYPASS_EN: an empty FIFO forwards slave data in the same cycle.
module respbuf
    import xbar_pkg::*;
#(
    parameter int unsigned WIDTH = XBAR_DATA_W,
    parameter int unsigned DEPTH = RESPBUF_DEPTH_DEF,
    parameter int unsigned CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_fire_i,
    input  logic             req_we_i,
    output logic             rd_allow_o,
    input  logic             slave_resp_i,
    input  logic [WIDTH-1:0] slave_rdata_bi,
    output logic             master_resp_o,
    output logic [WIDTH-1:0] master_rdata_bo,
    input  logic             master_ack_i,
    output logic             ovf_o
);

    logic [CNTW-1:0]  outstanding_q;
    logic             ovf_q;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             xfer;
    logic             read_fire;
    logic             cnt_inc;
    logic             cnt_dec;
    logic             err;

    respbuf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fifo_push),
        .wdata (slave_rdata_bi),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (fifo_rdata)
    );

    assign rd_allow_o = (outstanding_q < CNTW'(DEPTH));
    assign read_fire  = req_fire_i & ~req_we_i;
    assign ovf_o      = ovf_q;

    // Output selection, transfer detect and FIFO control.
    always_comb begin
        master_resp_o   = ~fifo_empty;
        master_rdata_bo = fifo_rdata;
        fifo_push       = slave_resp_i;
`ifdef RESPBUF_BYPASS_EN
        if (fifo_empty && slave_resp_i) begin
            master_resp_o   = 1'b1;
            master_rdata_bo = slave_rdata_bi;
            // Data taken straight through never touches the FIFO.
            fifo_push       = ~master_ack_i;
        end
`endif
        xfer     = master_resp_o & master_ack_i;
        fifo_pop = xfer & ~fifo_empty;
    end

    // Counter steps and error conditions; the decrement guard keeps a stray response
    // (already flagged) from wrapping the counter below zero.
    always_comb begin
        cnt_inc = read_fire & rd_allow_o;
        cnt_dec = xfer & (outstanding_q != '0);
        err     = (read_fire & ~rd_allow_o)
                | (slave_resp_i & fifo_full & ~fifo_pop)
                | (slave_resp_i & (outstanding_q == '0));
    end

    // Outstanding-read counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   outstanding_q <= outstanding_q + CNTW'(1);
                2'b01:   outstanding_q <= outstanding_q - CNTW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (err) begin
            ovf_q <= 1'b1;
        end
    end

endmodule

// File: doc/respbuf.md
Name: respbuf

Overview:
- Response-path buffer for the crossbar. It carries read responses from a slave port back toward a master port, the opposite direction to the request buffer.
- It holds up to DEPTH responses in a FIFO and counts outstanding reads.
- Read requests may only be issued while FIFO space is guaranteed for their responses, so the slave side never needs backpressure.
- One instance sits per master/slave path, next to the request buffer.

Parameters:
- WIDTH, 32, read-data width in bits.
- DEPTH, 4, response FIFO entries; power of 2, >= 2.
- CNTW, $clog2(DEPTH)+1, width of the outstanding counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- req_fire_i  input  1  request accepted this cycle (master_req & master_ack on the request path).
- req_we_i  input  1  write flag of the accepted request; 0 = read, which expects a response.
- rd_allow_o  output  1  a read may be issued this cycle; request-path arbitration must mask reads with it.
- slave_resp_i  input  1  slave returns read data this cycle; single-cycle pulse, no ack.
- slave_rdata_bi  input  WIDTH  slave read data.
- master_resp_o  output  1  response valid toward the master.
- master_rdata_bo  output  WIDTH  response data toward the master.
- master_ack_i  input  1  master accepts the response; transfer when master_resp_o & master_ack_i.
- ovf_o  output  1  sticky error: a response arrived with the FIFO full, or with no read outstanding.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - wr_ptr, rd_ptr, count, outstanding and ovf_o all go to 0; master_resp_o=0; master_rdata_bo=0.
  - A reset mid-operation discards all buffered and in-flight responses.
- Outstanding counter (CNTW bits):
  - Increment when req_fire_i & ~req_we_i.
  - Decrement on a master transfer (master_resp_o & master_ack_i).
  - Increment and decrement in the same cycle leave it unchanged.
  - rd_allow_o = (outstanding < DEPTH); combinational from registered state only.
  - A read fire while outstanding == DEPTH is a protocol error: ignore the increment and set ovf_o.
- FIFO write:
  - slave_resp_i pushes slave_rdata_bi at wr_ptr; wr_ptr wraps modulo DEPTH.
  - Push with count == DEPTH: drop the data and set ovf_o.
  - Push with outstanding == 0: set ovf_o; the data is still pushed if there is space.
- FIFO read and output, without bypass:
  - master_resp_o = (count != 0).
  - master_rdata_bo = mem[rd_ptr].
  - Latency is 1 cycle from slave_resp_i to master_resp_o.
- Transfer: rd_ptr advances on master_resp_o & master_ack_i. An ack with master_resp_o=0 is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at full (pop frees the slot in the same cycle) and at empty (bypass rules apply).
- master_rdata_bo holds stable while master_resp_o=1 and not acked.
- Responses return in order; no IDs.
- ovf_o clears only on reset.

Optional Feature:
- Macro: RESPBUF_BYPASS_EN.
- Defined:
  - When count == 0 and slave_resp_i=1: master_resp_o=1 and master_rdata_bo=slave_rdata_bi in the same cycle, with 0-cycle latency.
  - If master_ack_i=1 in that cycle, nothing is written to the FIFO and the pointers stay unchanged.
  - Otherwise the data is pushed as normal.
- Undefined: output is FIFO-only, registered, with 1-cycle minimum latency. The interface is identical in both builds.

Decomposition:
- Shared package xbar_pkg holds:
  - XBAR_DATA_W = 32.
  - XBAR_REQ_W = 67 (request bundle width).
  - RESPBUF_DEPTH_DEF = 4.
  - A typedef for the read-data word.
- One sub-module, respbuf_fifo: DEPTH x WIDTH register array with wr/rd pointers and count, exposing push, pop, full, empty and rdata.
- The respbuf top holds the outstanding counter, rd_allow, bypass muxing and ovf.

Test Plan:
- Reset, then 2 read fires, then slave_resp_i with 0xAAAA0001 and 0xAAAA0002 on consecutive cycles, ack held high -> master_resp_o rises 1 cycle after each push (bypass off), data in order, outstanding returns to 0, ovf_o=0.
- DEPTH=4: 4 read fires, master_ack_i=0 -> rd_allow_o=0 after the 4th fire; 4 responses fill the FIFO; first ack -> rd_allow_o=1 the next cycle.
- FIFO full, then slave_resp_i with 0xDEAD and master_ack_i=1 in the same cycle -> 0xDEAD accepted, count stays 4, ovf_o=0.
- FIFO full, no ack, extra slave_resp_i -> data dropped, ovf_o=1 and sticky; a later reset clears it.
- Write fire (req_we_i=1) followed by slave_resp_i with 0 outstanding -> ovf_o=1; write fires never change outstanding.
- RESPBUF_BYPASS_EN defined, FIFO empty, slave_resp_i with 0x1234 and ack=1 -> master_resp_o=1 with 0x1234 the same cycle; count stays 0. Reset asserted with 2 entries buffered -> master_resp_o=0 the next cycle.
